uart_cfg_rx: RTL and testbench

UART_CFG_RX -- requirements
Module: uart_cfg_rx

---
 rtl/uart_cfg_rx.sv | 205 ++++++++++++++++++++
 tb/tb_uart_cfg_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_rx.sv
// uart_cfg_rx: UART receiver whose frames write a small configuration
// register file. Upper frame bits select the register, lower bits carry the value.
module uart_cfg_rx #(
    parameter int unsigned CLKS_PER_BIT = 32,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 1,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned ADDR_BITS    = 4,
    parameter int unsigned NUM_REGS     = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          Rx,
    output logic [DATA_BITS-1:0]                          rx_data,
    output logic                                          rx_valid,
    output logic                                          parity_err,
    output logic                                          frame_err,
    output logic                                          busy,
    output logic                                          wr_strobe,
    output logic [ADDR_BITS-1:0]                          wr_addr,
    output logic [NUM_REGS*(DATA_BITS-ADDR_BITS)-1:0]     regs_flat
);

    localparam int unsigned VAL_W = DATA_BITS - ADDR_BITS;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic             PAR_ODD = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0]    shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    ferr_q, ferr_d;
    logic                    wait_q, wait_d;
    logic                    rx_meta_q, rx_s_q;
    logic                    done_c;
    logic                    ferr_now_c;
    logic                    addr_ok_c;

    logic [DATA_BITS-1:0]    rx_data_q;
    logic                    rx_valid_q, parity_err_q, frame_err_q, busy_q, wr_strobe_q;
    logic [ADDR_BITS-1:0]    wr_addr_q;
    logic [NUM_REGS*VAL_W-1:0] regs_q;

    // Two-flop synchronizer for the asynchronous serial line, idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // FSM and datapath state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic: mid-bit sampling driven by the cycle counter
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ferr_d     = ferr_q;
        wait_d     = wait_q;
        done_c     = 1'b0;
        ferr_now_c = ferr_q | ~rx_s_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // After a framing error the line may still be low; wait for idle
                if (wait_q) begin
                    if (rx_s_q) wait_d = 1'b0;
                end else if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        par_d   = 1'b0;
                        ferr_d  = 1'b0;
                        state_d = (PARITY == 0) ? S_STOP : S_PARITY;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = (^shift_q) ^ rx_s_q ^ PAR_ODD;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d  = '0;
                    ferr_d = ferr_now_c;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        done_c  = 1'b1;
                        wait_d  = ferr_now_c;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign addr_ok_c = ({1'b0, shift_q[DATA_BITS-1 -: ADDR_BITS]} < (ADDR_BITS + 1)'(NUM_REGS));

    // Frame result registers; a clean in-range frame also issues a register write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
        end else begin
            rx_valid_q  <= done_c;
            wr_strobe_q <= 1'b0;
            busy_q      <= (state_d != S_IDLE);
            if (done_c) begin
                rx_data_q    <= shift_q;
                parity_err_q <= par_q;
                frame_err_q  <= ferr_now_c;
                if (!par_q && !ferr_now_c && addr_ok_c) begin
                    wr_strobe_q <= 1'b1;
                    wr_addr_q   <= shift_q[DATA_BITS-1 -: ADDR_BITS];
                end
            end
        end
    end

    // Register file, written in the strobe cycle and visible the cycle after
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (wr_strobe_q && (wr_addr_q == ADDR_BITS'(i)))
                    regs_q[i*VAL_W +: VAL_W] <= rx_data_q[VAL_W-1:0];
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign regs_flat  = regs_q;

endmodule

// File: tb/tb_uart_cfg_rx.sv
// Bench for uart_cfg_rx with default parameters: 10 ns clock, 32 clocks per bit.
module tb_uart_cfg_rx;

    localparam int CPB = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Rx  = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid, parity_err, frame_err, busy, wr_strobe;
    logic [3:0]  wr_addr;
    logic [31:0] regs_flat;

    uart_cfg_rx dut (
        .clk(clk), .rst(rst), .Rx(Rx),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err),
        .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .regs_flat(regs_flat)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Monitor: counts pulses and captures frame results away from the clock edge
    int          vcnt = 0;
    int          wcnt = 0;
    logic [7:0]  c_data;
    logic        c_perr, c_ferr;
    logic [3:0]  c_addr;
    logic [31:0] c_regs_next;
    bit          pend = 1'b0;

    always @(negedge clk) begin
        if (pend) c_regs_next = regs_flat;
        pend = rx_valid;
        if (rx_valid) begin
            vcnt++;
            c_data = rx_data;
            c_perr = parity_err;
            c_ferr = frame_err;
        end
        if (wr_strobe) begin
            wcnt++;
            c_addr = wr_addr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        Rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Even parity on the line; pflip inverts it, stop_low drives the stop bit low
    task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stop_low);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit((^d) ^ pflip);
        drive_bit(~stop_low);
        Rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        bit         pflip;
        bit         stop_low;
        logic [7:0] e_data;
        bit         e_perr;
        bit         e_ferr;
        bit         e_wr;
        logic [3:0] e_addr;
        logic [3:0] e_val;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] model_regs = '0;

    initial begin
        int v0, w0;

        vecs[0] = '{8'h35, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0, 1'b1, 4'h3, 4'h5};
        vecs[1] = '{8'h4A, 1'b1, 1'b0, 8'h4A, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0};
        vecs[2] = '{8'h5D, 1'b0, 1'b1, 8'h5D, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0};
        vecs[3] = '{8'h9A, 1'b0, 1'b0, 8'h9A, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
        vecs[4] = '{8'h7C, 1'b0, 1'b0, 8'h7C, 1'b0, 1'b0, 1'b1, 4'h7, 4'hC};
        vecs[5] = '{8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, 4'h0, 4'hF};
        vecs[6] = '{8'h21, 1'b1, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};

        // Reset state
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rx_data", 32'(rx_data), 32'h0);
        chk("reset_flags", {27'h0, rx_valid, parity_err, frame_err, busy, wr_strobe}, 32'h0);
        chk("reset_wr_addr", 32'(wr_addr), 32'h0);
        chk("reset_regs", regs_flat, 32'h0);
        repeat (4) @(posedge clk);
        #1;

        // Table-driven single frames
        for (int k = 0; k < 7; k++) begin
            v0 = vcnt;
            w0 = wcnt;
            send_frame(vecs[k].d, vecs[k].pflip, vecs[k].stop_low);
            repeat (2 * CPB) @(posedge clk);
            @(negedge clk);
            if (vecs[k].e_wr) model_regs[vecs[k].e_addr*4 +: 4] = vecs[k].e_val;
            chk($sformatf("v%0d_valid_count", k), 32'(vcnt - v0), 32'd1);
            chk($sformatf("v%0d_rx_data", k), 32'(c_data), 32'(vecs[k].e_data));
            chk($sformatf("v%0d_parity_err", k), 32'(c_perr), 32'(vecs[k].e_perr));
            chk($sformatf("v%0d_frame_err", k), 32'(c_ferr), 32'(vecs[k].e_ferr));
            chk($sformatf("v%0d_wr_count", k), 32'(wcnt - w0), 32'(vecs[k].e_wr));
            chk($sformatf("v%0d_hold_rx_data", k), 32'(rx_data), 32'(vecs[k].e_data));
            chk($sformatf("v%0d_hold_flags", k), {30'h0, parity_err, frame_err},
                {30'h0, vecs[k].e_perr, vecs[k].e_ferr});
            if (vecs[k].e_wr) begin
                chk($sformatf("v%0d_wr_addr", k), 32'(c_addr), 32'(vecs[k].e_addr));
                chk($sformatf("v%0d_reg_next_cycle", k), c_regs_next, model_regs);
            end
            chk($sformatf("v%0d_regs", k), regs_flat, model_regs);
            chk($sformatf("v%0d_busy_idle", k), 32'(busy), 32'h0);
        end

        // Back-to-back frames with no idle gap
        v0 = vcnt;
        send_frame(8'h12, 1'b0, 1'b0);
        send_frame(8'h23, 1'b0, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        model_regs[1*4 +: 4] = 4'h2;
        model_regs[2*4 +: 4] = 4'h3;
        chk("b2b_valid_count", 32'(vcnt - v0), 32'd2);
        chk("b2b_rx_data", 32'(c_data), 32'h23);
        chk("b2b_regs", regs_flat, model_regs);

        // 100 ns low glitch on an idle line
        v0 = vcnt;
        Rx = 1'b0;
        #100;
        Rx = 1'b1;
        @(negedge clk);
        chk("glitch_busy_high", 32'(busy), 32'h1);
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_low", 32'(busy), 32'h0);
        chk("glitch_no_valid", 32'(vcnt - v0), 32'd0);

        // Reset in the middle of 0x61, then a clean 0x7E
        v0 = vcnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d61;
            d61 = 8'h61;
            drive_bit(d61[i]);
        end
        rst = 1'b1;
        Rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        model_regs = '0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_regs_cleared", regs_flat, 32'h0);
        repeat (CPB) @(posedge clk);
        #1;
        send_frame(8'h7E, 1'b0, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        model_regs[7*4 +: 4] = 4'hE;
        chk("midrst_valid_count", 32'(vcnt - v0), 32'd1);
        chk("midrst_rx_data", 32'(c_data), 32'h7E);
        chk("midrst_reg7", 32'(regs_flat[28 +: 4]), 32'hE);
        chk("midrst_reg6", 32'(regs_flat[24 +: 4]), 32'h0);
        chk("midrst_regs", regs_flat, model_regs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
